// File: rtl/alu_status_pkg.sv
// Shared definitions for the ALU status/exception stage: status bit positions,
// exception cause codes, FSM state encoding and default trap configuration.
package alu_status_pkg;

  localparam int BIT_ZERO     = 7;
  localparam int BIT_OVF      = 6;
  localparam int BIT_CARRY    = 5;
  localparam int BIT_NEG      = 4;
  localparam int BIT_INV_ADDR = 3;
  localparam int BIT_DIV0     = 2;

  // Only overflow and divide-by-zero trap out of the box; zero/negative never can.
  localparam logic [7:0] DEFAULT_EXC_MASK    = 8'b0100_0100;
  localparam int         DEFAULT_ACK_TIMEOUT = 16;

  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_OVF      = 3'd1,
    CAUSE_CARRY    = 3'd2,
    CAUSE_INV_ADDR = 3'd3,
    CAUSE_DIV0     = 3'd4
  } cause_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

endpackage

// File: rtl/exc_cause_encoder.sv
// Priority encoder turning the trappable status bits of one instruction into
// a cause code: overflow > carry > invalid address > divide-by-zero.
module exc_cause_encoder
  import alu_status_pkg::*;
(
  input  logic       ovf,
  input  logic       carry,
  input  logic       inv_addr,
  input  logic       div0,
  output logic [2:0] cause,
  output logic       fault
);

  always_comb begin
    cause = CAUSE_NONE;
    if (ovf)
      cause = CAUSE_OVF;
    else if (carry)
      cause = CAUSE_CARRY;
    else if (inv_addr)
      cause = CAUSE_INV_ADDR;
    else if (div0)
      cause = CAUSE_DIV0;
  end

  assign fault = ovf | carry | inv_addr | div0;

endmodule

// File: rtl/alu_status_handler.sv
// Post-ALU stage: registers result/status, keeps the sticky status register and
// runs the fault -> flush -> wait-for-ack exception handshake with a timeout.
module alu_status_handler
  import alu_status_pkg::*;
#(
  parameter logic [7:0] EXC_MASK    = DEFAULT_EXC_MASK,
  parameter int         ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ALU_result,
  input  logic [7:0]  ALU_status,
  input  logic        exc_ack,
  input  logic        sr_clear,
  output logic [31:0] result_q,
  output logic [7:0]  status_q,
  output logic [7:0]  sticky_q,
  output logic        exc_req,
  output logic [2:0]  exc_cause,
  output logic [31:0] epc,
  output logic        flush,
  output logic        stall,
  output logic        ack_timeout
);

  localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [7:0]       sticky_next;
  logic [2:0]       enc_cause;
  logic             enc_fault;
  logic             accept;
  logic             trap;
  logic             ack_taken;

  exc_cause_encoder u_cause_enc (
    .ovf      (ALU_status[BIT_OVF]      & EXC_MASK[BIT_OVF]),
    .carry    (ALU_status[BIT_CARRY]    & EXC_MASK[BIT_CARRY]),
    .inv_addr (ALU_status[BIT_INV_ADDR] & EXC_MASK[BIT_INV_ADDR]),
    .div0     (ALU_status[BIT_DIV0]     & EXC_MASK[BIT_DIV0]),
    .cause    (enc_cause),
    .fault    (enc_fault)
  );

  always_comb begin
    state_next  = state;
    flush       = 1'b0;
    stall       = 1'b0;
    exc_req     = 1'b0;
    ack_timeout = 1'b0;
    accept      = 1'b0;
    trap        = 1'b0;
    ack_taken   = 1'b0;

    case (state)
      ST_IDLE: begin
        accept = ex_valid;
        if (ex_valid && enc_fault) begin
          trap       = 1'b1;
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        flush      = 1'b1;
        stall      = 1'b1;
        exc_req    = 1'b1;
        state_next = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        stall   = 1'b1;
        exc_req = 1'b1;
        // An ack arriving on the final wait cycle still wins over the timeout.
        if (exc_ack) begin
          ack_taken  = 1'b1;
          state_next = ST_IDLE;
        end else if (wait_cnt == CNT_LAST) begin
          ack_timeout = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Software clear happens before the new status is folded in.
    sticky_next = sr_clear ? 8'h00 : sticky_q;
    if (accept)
      sticky_next = sticky_next | ALU_status;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      result_q  <= '0;
      status_q  <= '0;
      sticky_q  <= '0;
      exc_cause <= CAUSE_NONE;
      epc       <= '0;
    end else begin
      state    <= state_next;
      sticky_q <= sticky_next;

      if (accept) begin
        result_q <= ALU_result;
        status_q <= ALU_status;
      end

      if (trap) begin
        epc       <= ex_pc;
        exc_cause <= enc_cause;
      end else if (ack_taken) begin
        exc_cause <= CAUSE_NONE;
      end

      if (state == ST_WAIT_ACK && state_next == ST_WAIT_ACK)
        wait_cnt <= wait_cnt + CNT_W'(1);
      else
        wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_alu_status_handler.sv
// Self-checking bench for alu_status_handler: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_alu_status_handler;

  localparam logic [7:0] MASK    = 8'b0100_0100;
  localparam int         TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ALU_result = '0;
  logic [7:0]  ALU_status = '0;
  logic        exc_ack = 1'b0;
  logic        sr_clear = 1'b0;
  logic [31:0] result_q;
  logic [7:0]  status_q;
  logic [7:0]  sticky_q;
  logic        exc_req;
  logic [2:0]  exc_cause;
  logic [31:0] epc;
  logic        flush;
  logic        stall;
  logic        ack_timeout;

  int errors = 0;
  int checks = 0;
  logic checking = 1'b0;

  alu_status_handler #(.EXC_MASK(MASK), .ACK_TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ALU_result  (ALU_result),
    .ALU_status  (ALU_status),
    .exc_ack     (exc_ack),
    .sr_clear    (sr_clear),
    .result_q    (result_q),
    .status_q    (status_q),
    .sticky_q    (sticky_q),
    .exc_req     (exc_req),
    .exc_cause   (exc_cause),
    .epc         (epc),
    .flush       (flush),
    .stall       (stall),
    .ack_timeout (ack_timeout)
  );

  always #5 clk = ~clk;

  // Reference model: m_age counts cycles since a fault was taken
  // (0 = no exception, 1 = flush cycle, 2..TIMEOUT+1 = waiting for ack).
  logic [31:0] m_result, m_epc;
  logic [7:0]  m_status, m_sticky;
  int          m_cause, m_age;

  function automatic int expected_cause(input logic [7:0] st);
    int bits[4]  = '{6, 5, 3, 2};
    int codes[4] = '{1, 2, 3, 4};
    logic [7:0] trappable;
    trappable = st & MASK;
    for (int i = 0; i < 4; i++)
      if (trappable[bits[i]]) return codes[i];
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_result = '0; m_status = '0; m_sticky = '0; m_epc = '0;
      m_cause = 0; m_age = 0;
    end else begin
      if (sr_clear) m_sticky = 8'h00;
      if (m_age == 0) begin
        if (ex_valid) begin
          m_result = ALU_result;
          m_status = ALU_status;
          m_sticky = m_sticky | ALU_status;
          if (expected_cause(ALU_status) != 0) begin
            m_epc   = ex_pc;
            m_cause = expected_cause(ALU_status);
            m_age   = 1;
          end
        end
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (exc_ack) begin
        m_age = 0;
        m_cause = 0;
      end else if (m_age == TIMEOUT + 1) begin
        m_age = 0;
      end else begin
        m_age = m_age + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model, after the driver has set inputs.
  always @(negedge clk) begin
    #4;
    if (checking) begin
      checkOutput("m.result_q", result_q, m_result);
      checkOutput("m.status_q", {24'd0, status_q}, {24'd0, m_status});
      checkOutput("m.sticky_q", {24'd0, sticky_q}, {24'd0, m_sticky});
      checkOutput("m.epc", epc, m_epc);
      checkOutput("m.exc_cause", {29'd0, exc_cause}, 32'(m_cause));
      checkOutput("m.exc_req", {31'd0, exc_req}, {31'd0, m_age != 0});
      checkOutput("m.stall", {31'd0, stall}, {31'd0, m_age != 0});
      checkOutput("m.flush", {31'd0, flush}, {31'd0, m_age == 1});
      checkOutput("m.ack_timeout", {31'd0, ack_timeout},
                  {31'd0, (m_age == TIMEOUT + 1) && !exc_ack});
    end
  end

  // Drives one cycle of inputs and returns once that cycle's edge has settled.
  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] res,
                               input logic [7:0] st, input logic ack, input logic clr);
    ex_valid = v; ex_pc = pc; ALU_result = res; ALU_status = st;
    exc_ack = ack; sr_clear = clr;
    @(negedge clk);
    #3;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'd0, 32'd0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(negedge clk);
    #3;
    checkOutput("reset.exc_req", {31'd0, exc_req}, 32'd0);
    checkOutput("reset.sticky_q", {24'd0, sticky_q}, 32'd0);
    checkOutput("reset.flush", {31'd0, flush}, 32'd0);
    rst_n = 1'b1;
    checking = 1'b1;

    // Non-trapping zero flag
    applyStimulus(1'b1, 32'h0000_1000, 32'd0, 8'h80, 1'b0, 1'b0);
    checkOutput("t1.status_q", {24'd0, status_q}, 32'h80);
    checkOutput("t1.sticky_q", {24'd0, sticky_q}, 32'h80);
    checkOutput("t1.exc_req", {31'd0, exc_req}, 32'd0);
    checkOutput("t1.flush", {31'd0, flush}, 32'd0);

    // Overflow + div0: overflow wins, acked on the third wait cycle
    applyStimulus(1'b1, 32'h0040_0010, 32'h1234, 8'h44, 1'b0, 1'b0);
    checkOutput("t2.epc", epc, 32'h0040_0010);
    checkOutput("t2.cause", {29'd0, exc_cause}, 32'd1);
    checkOutput("t2.flush", {31'd0, flush}, 32'd1);
    checkOutput("t2.stall", {31'd0, stall}, 32'd1);
    idleCycle();
    checkOutput("t2.flush_gone", {31'd0, flush}, 32'd0);
    checkOutput("t2.exc_req_wait", {31'd0, exc_req}, 32'd1);
    idleCycle();
    idleCycle();
    applyStimulus(1'b0, 32'd0, 32'd0, 8'h00, 1'b1, 1'b0);
    checkOutput("t2.exc_req_after_ack", {31'd0, exc_req}, 32'd0);
    checkOutput("t2.cause_after_ack", {29'd0, exc_cause}, 32'd0);

    // Div0 with no ack: times out after TIMEOUT wait cycles
    applyStimulus(1'b1, 32'h0040_0020, 32'h55, 8'h04, 1'b0, 1'b0);
    checkOutput("t3.cause", {29'd0, exc_cause}, 32'd4);
    for (int i = 1; i <= TIMEOUT; i++) begin
      idleCycle();
      if (i == TIMEOUT - 1)
        checkOutput("t3.no_early_timeout", {31'd0, ack_timeout}, 32'd0);
    end
    checkOutput("t3.exc_req_last", {31'd0, exc_req}, 32'd1);
    checkOutput("t3.ack_timeout", {31'd0, ack_timeout}, 32'd1);
    idleCycle();
    checkOutput("t3.exc_req_after", {31'd0, exc_req}, 32'd0);
    checkOutput("t3.ack_timeout_gone", {31'd0, ack_timeout}, 32'd0);

    // Second faulting instruction is held off until the first is acked
    applyStimulus(1'b1, 32'h0000_0100, 32'h1, 8'h40, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0200, 32'h2, 8'h40, 1'b0, 1'b0);
    checkOutput("t4.epc_held", epc, 32'h0000_0100);
    checkOutput("t4.result_held", result_q, 32'h1);
    checkOutput("t4.sticky_held", {24'd0, sticky_q}, 32'hC4);
    applyStimulus(1'b1, 32'h0000_0200, 32'h2, 8'h40, 1'b1, 1'b0);
    checkOutput("t4.result_after_ack", result_q, 32'h1);
    applyStimulus(1'b1, 32'h0000_0200, 32'h2, 8'h40, 1'b0, 1'b0);
    checkOutput("t4.second_epc", epc, 32'h0000_0200);
    checkOutput("t4.second_result", result_q, 32'h2);
    idleCycle();
    applyStimulus(1'b0, 32'd0, 32'd0, 8'h00, 1'b1, 1'b0);

    // Clear and accept in the same cycle
    applyStimulus(1'b0, 32'd0, 32'd0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h0000_0300, 32'h3, 8'h10, 1'b0, 1'b0);
    checkOutput("t5.sticky_neg", {24'd0, sticky_q}, 32'h10);
    applyStimulus(1'b1, 32'h0000_0304, 32'h4, 8'h80, 1'b0, 1'b1);
    checkOutput("t5.sticky_clear_or", {24'd0, sticky_q}, 32'h80);

    // Asynchronous reset while waiting for ack
    applyStimulus(1'b1, 32'h0000_0400, 32'h5, 8'h40, 1'b0, 1'b0);
    idleCycle();
    idleCycle();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6.exc_req", {31'd0, exc_req}, 32'd0);
    checkOutput("t6.stall", {31'd0, stall}, 32'd0);
    checkOutput("t6.epc", epc, 32'd0);
    checkOutput("t6.sticky_q", {24'd0, sticky_q}, 32'd0);
    @(negedge clk);
    #3;
    rst_n = 1'b1;

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] st;
      st = 8'($urandom) & (($urandom_range(0, 3) == 0) ? 8'hFF : 8'hBB);
      applyStimulus($urandom_range(0, 1) == 1, $urandom, $urandom, st,
                    $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0);
    end

    checking = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
